regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the single-write, two-read decode-stage register file.
- Adds a configurable number of read ports and same-cycle write-to-read bypass.
- Adds a per-register scoreboard of in-flight writes, with an issue handshake and per-port busy flags for hazard stalls.
- Sits in decode: read ports index from the fetched instruction, the write port is driven from the memory stage, and scoreboard issue comes from decode when an instruction with a register destination is accepted.

Parameters:
DATA_W, 32, register data width in bits
NREG, 32, number of architectural registers; register 0 reads as 0
AW, 5, register index width; NREG <= 2**AW
NRD, 2, number of read ports
CNT_W, 2, width of each per-register pending-write counter; max in-flight writes per register = 2**CNT_W-1

Ports:
clk  input  1  clock, all state updates on rising edge
flush  input  1  asynchronous active-high reset
ra  input  NRD*AW  read addresses, port i at [i*AW +: AW]
rd  output  NRD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
busy  output  NRD  port i source register has a pending write not yet committed
we  input  1  write enable (already stall-gated by caller)
wa  input  AW  write address
wd  input  DATA_W  write data
wr_commit  input  1  write retires one scoreboard entry for wa (independent of we)
iss_valid  input  1  decode requests scoreboard entry for iss_reg
iss_reg  input  AW  destination register of issuing instruction
iss_ready  output  1  scoreboard can accept iss_reg this cycle
pend_any  output  1  at least one register has nonzero pending count

Behaviour:
- Reset: flush high asynchronously clears all storage registers to 0 and all pending counters to 0. While flush is high: rd=0, busy=0, iss_ready=1, pend_any=0.
- Storage: NREG x DATA_W. On posedge clk, if we and wa!=0 and wa<NREG, then mem[wa] <= wd. Writes to 0 or to an out-of-range index are discarded.
- Read, combinational, per port i:
  - ra_i==0 or ra_i>=NREG -> 0.
  - else if we and wa==ra_i -> wd (bypass: same-cycle write visible).
  - else mem[ra_i].
- Scoreboard: counter cnt[r] per register r=1..NREG-1; cnt[0] is constant 0.
  - Issue fires when iss_valid && iss_ready && iss_reg!=0 && iss_reg<NREG.
  - iss_ready = 0 iff iss_reg in range, nonzero, and cnt[iss_reg]==2**CNT_W-1; else 1. iss_ready depends only on iss_reg and state, not on iss_valid.
  - Issue to r0 or out of range: no effect, handshake still completes.
  - Commit fires when wr_commit && wa!=0 && wa<NREG && cnt[wa]!=0. Commit with cnt==0 is ignored (no underflow).
  - Per register, on posedge clk: issue only -> +1; commit only -> -1; issue and commit to the same register in the same cycle -> unchanged. Issue and commit to different registers update independently.
- busy[i] = (cnt[ra_i]!=0) and not (wr_commit && wa==ra_i && cnt[ra_i]==1). The last pending write committing this cycle releases busy combinationally, consistent with the bypass.
- pend_any = OR of cnt[r]!=0, registered state only (no bypass term).
- Latency: a write is visible in the same cycle via bypass and from storage the next cycle. An issue makes busy visible from the next cycle.
- Flush mid-operation: counters and storage clear immediately. Writes or issues in the flush cycle are lost.

Test Plan:
- Reset: assert flush with nonzero state -> all rd=0, busy=0, pend_any=0, iss_ready=1; release flush, read r5 -> 0.
- Bypass: we=1, wa=7, wd=0xDEADBEEF, ra port0=7, port1=0 in the same cycle -> rd0=0xDEADBEEF, rd1=0. Next cycle with we=0 -> rd0=0xDEADBEEF. Write to r0 with wd=0x1234 -> r0 still reads 0.
- Scoreboard basic: issue r3 -> next cycle busy for port reading r3 =1, pend_any=1. wr_commit with wa=3, cnt=1 -> busy=0 in that same cycle; next cycle pend_any=0.
- Saturation (CNT_W=2): issue r9 three times -> iss_ready=0 while iss_reg=9; fourth issue has no effect. Three commits to r9 -> cnt returns to 0; a fourth commit is ignored, no underflow.
- Simultaneous events: cnt[4]=1, issue r4 and commit r4 in the same cycle -> cnt stays 1, busy stays 1. Issue r2 with commit r4 -> cnt[2]=1, cnt[4]=0.
- NRD=4, DATA_W=16 instance: four distinct registers read correctly with independent busy bits. Flush asserted mid-sequence (cnt[6]=2) -> busy and storage clear asynchronously.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: decode-stage register file with a per-register scoreboard.
//
// Parameters: DATA_W data width, NREG registers (r0 reads 0), AW index width,
// NRD read ports, CNT_W pending-write counter width per register.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   flush      asynchronous active-high reset of storage and scoreboard
//   ra         read addresses, port i at [i*AW +: AW]
//   rd         read data, port i at [i*DATA_W +: DATA_W]
//   busy       port i source register has an uncommitted pending write
//   we/wa/wd   write port (enable, address, data) from the memory stage
//   wr_commit  retire one scoreboard entry for wa
//   iss_valid  decode requests a scoreboard entry for iss_reg
//   iss_reg    destination register of the issuing instruction
//   iss_ready  scoreboard can accept iss_reg this cycle
//   pend_any   some register has a nonzero pending count
module regfile_sb #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NREG   = 32,
   parameter int unsigned AW     = 5,
   parameter int unsigned NRD    = 2,
   parameter int unsigned CNT_W  = 2
) (
   input  logic                  clk,
   input  logic                  flush,
   input  logic [NRD*AW-1:0]     ra,
   output logic [NRD*DATA_W-1:0] rd,
   output logic [NRD-1:0]        busy,
   input  logic                  we,
   input  logic [AW-1:0]         wa,
   input  logic [DATA_W-1:0]     wd,
   input  logic                  wr_commit,
   input  logic                  iss_valid,
   input  logic [AW-1:0]         iss_reg,
   output logic                  iss_ready,
   output logic                  pend_any
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   // Index names a real, writable register (not r0, not past NREG).
   function automatic logic f_valid(input logic [AW-1:0] a);
      return (a != '0) && (32'(a) < NREG);
   endfunction

   logic [DATA_W-1:0] r_mem [NREG];
   logic [CNT_W-1:0]  r_cnt [NREG];

   logic              w_wa_ok;
   logic              w_iss_ok;
   logic [CNT_W-1:0]  w_cnt_wa;
   logic [CNT_W-1:0]  w_cnt_iss;
   logic              w_iss_fire;
   logic              w_cmt_fire;

   assign w_wa_ok   = f_valid(wa);
   assign w_iss_ok  = f_valid(iss_reg);
   assign w_cnt_wa  = w_wa_ok  ? r_cnt[wa]      : '0;
   assign w_cnt_iss = w_iss_ok ? r_cnt[iss_reg] : '0;

   assign iss_ready  = !(w_iss_ok && (w_cnt_iss == CntMax));
   assign w_iss_fire = iss_valid && iss_ready && w_iss_ok;
   // A commit against an empty counter is dropped so the count cannot wrap.
   assign w_cmt_fire = wr_commit && w_wa_ok && (w_cnt_wa != '0);

   // Read ports: combinational, with same-cycle write bypass.
   for (genvar g = 0; g < NRD; g++) begin : g_port
      logic [AW-1:0]     w_ra;
      logic              w_ok;
      logic [CNT_W-1:0]  w_cnt;
      logic [DATA_W-1:0] w_data;

      assign w_ra   = ra[g*AW +: AW];
      assign w_ok   = f_valid(w_ra);
      assign w_cnt  = w_ok ? r_cnt[w_ra] : '0;
      assign w_data = !w_ok                ? '0 :
                      (we && (wa == w_ra)) ? wd : r_mem[w_ra];
      // Bypass must not leak through while flush holds the file in reset.
      assign rd[g*DATA_W +: DATA_W] = flush ? '0 : w_data;
      // The last outstanding write committing now releases busy immediately,
      // matching the data the bypass is already presenting.
      assign busy[g] = (w_cnt != '0) &&
                       !(wr_commit && (wa == w_ra) && (w_cnt == CntOne));
   end

   // Storage
   always_ff @(posedge clk or posedge flush) begin
      if (flush) begin
         for (int r = 0; r < NREG; r++) begin
            r_mem[r] <= '0;
         end
      end else if (we && w_wa_ok) begin
         r_mem[wa] <= wd;
      end
   end

   // Scoreboard counters; r_cnt[0] stays at its reset value of 0.
   always_ff @(posedge clk or posedge flush) begin
      if (flush) begin
         for (int r = 0; r < NREG; r++) begin
            r_cnt[r] <= '0;
         end
      end else begin
         for (int r = 1; r < NREG; r++) begin
            if ((w_iss_fire && (iss_reg == AW'(r))) &&
                !(w_cmt_fire && (wa == AW'(r)))) begin
               r_cnt[r] <= r_cnt[r] + CntOne;
            end else if ((w_cmt_fire && (wa == AW'(r))) &&
                         !(w_iss_fire && (iss_reg == AW'(r)))) begin
               r_cnt[r] <= r_cnt[r] - CntOne;
            end
         end
      end
   end

   always_comb begin
      pend_any = 1'b0;
      for (int r = 1; r < NREG; r++) begin
         pend_any = pend_any | (r_cnt[r] != '0);
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed, table-driven bench for regfile_sb.
// Instance A uses default parameters; instance B uses NRD=4, DATA_W=16.
module tb_regfile_sb;

   logic clk;
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instance A (defaults)
   logic        a_flush;
   logic [9:0]  a_ra;
   logic [63:0] a_rd;
   logic [1:0]  a_busy;
   logic        a_we;
   logic [4:0]  a_wa;
   logic [31:0] a_wd;
   logic        a_cm;
   logic        a_iv;
   logic [4:0]  a_ir;
   logic        a_rdy;
   logic        a_pend;

   regfile_sb u_dut_a (
      .clk       (clk),
      .flush     (a_flush),
      .ra        (a_ra),
      .rd        (a_rd),
      .busy      (a_busy),
      .we        (a_we),
      .wa        (a_wa),
      .wd        (a_wd),
      .wr_commit (a_cm),
      .iss_valid (a_iv),
      .iss_reg   (a_ir),
      .iss_ready (a_rdy),
      .pend_any  (a_pend)
   );

   // Instance B (4 read ports, 16-bit data)
   logic        b_flush;
   logic [19:0] b_ra;
   logic [63:0] b_rd;
   logic [3:0]  b_busy;
   logic        b_we;
   logic [4:0]  b_wa;
   logic [15:0] b_wd;
   logic        b_cm;
   logic        b_iv;
   logic [4:0]  b_ir;
   logic        b_rdy;
   logic        b_pend;

   regfile_sb #(
      .DATA_W (16),
      .NRD    (4)
   ) u_dut_b (
      .clk       (clk),
      .flush     (b_flush),
      .ra        (b_ra),
      .rd        (b_rd),
      .busy      (b_busy),
      .we        (b_we),
      .wa        (b_wa),
      .wd        (b_wd),
      .wr_commit (b_cm),
      .iss_valid (b_iv),
      .iss_reg   (b_ir),
      .iss_ready (b_rdy),
      .pend_any  (b_pend)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        cm;
      logic        iv;
      logic [4:0]  ir;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e_rd0;
      logic [31:0] e_rd1;
      logic [1:0]  e_busy;
      logic        e_rdy;
      logic        e_pend;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic cm, input logic iv, input logic [4:0] ir,
                      input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                      input logic [1:0] e_busy, input logic e_rdy, input logic e_pend);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.cm = cm; v.iv = iv; v.ir = ir;
      v.ra0 = ra0; v.ra1 = ra1; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
      v.e_busy = e_busy; v.e_rdy = e_rdy; v.e_pend = e_pend;
      tv.push_back(v);
   endtask

   task automatic a_idle();
      a_we = 1'b0; a_wa = '0; a_wd = '0; a_cm = 1'b0; a_iv = 1'b0; a_ir = '0; a_ra = '0;
   endtask

   task automatic b_idle();
      b_we = 1'b0; b_wa = '0; b_wd = '0; b_cm = 1'b0; b_iv = 1'b0; b_ir = '0; b_ra = '0;
   endtask

   initial begin
      // Columns: we wa wd cm iv ir ra0 ra1 | rd0 rd1 busy ready pend
      add(0, 0, 32'h0,        0, 0, 0, 5, 0, 32'h0,        32'h0,        2'b00, 1, 0);
      // Bypass and r0 write discard
      add(1, 7, 32'hDEADBEEF, 0, 0, 0, 7, 0, 32'hDEADBEEF, 32'h0,        2'b00, 1, 0);
      add(0, 0, 32'h0,        0, 0, 0, 7, 7, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 0);
      add(1, 0, 32'h1234,     0, 0, 0, 0, 7, 32'h0,        32'hDEADBEEF, 2'b00, 1, 0);
      add(0, 0, 32'h0,        0, 0, 0, 0, 5, 32'h0,        32'h0,        2'b00, 1, 0);
      // Scoreboard basic on r3, commit with bypassed write
      add(0, 0, 32'h0,        0, 1, 3, 3, 7, 32'h0,        32'hDEADBEEF, 2'b00, 1, 0);
      add(0, 0, 32'h0,        0, 0, 0, 3, 7, 32'h0,        32'hDEADBEEF, 2'b01, 1, 1);
      add(1, 3, 32'h33,       1, 0, 0, 3, 7, 32'h33,       32'hDEADBEEF, 2'b00, 1, 1);
      add(0, 0, 32'h0,        0, 0, 0, 3, 0, 32'h33,       32'h0,        2'b00, 1, 0);
      // Saturation on r9
      add(0, 0, 32'h0,        0, 1, 9, 9, 3, 32'h0,        32'h33,       2'b00, 1, 0);
      add(0, 0, 32'h0,        0, 1, 9, 9, 3, 32'h0,        32'h33,       2'b01, 1, 1);
      add(0, 0, 32'h0,        0, 1, 9, 9, 3, 32'h0,        32'h33,       2'b01, 1, 1);
      add(0, 0, 32'h0,        0, 1, 9, 9, 3, 32'h0,        32'h33,       2'b01, 0, 1);
      add(0, 0, 32'h0,        0, 0, 9, 9, 3, 32'h0,        32'h33,       2'b01, 0, 1);
      add(0, 0, 32'h0,        0, 0, 5, 9, 3, 32'h0,        32'h33,       2'b01, 1, 1);
      add(0, 9, 32'h0,        1, 0, 9, 9, 3, 32'h0,        32'h33,       2'b01, 0, 1);
      add(0, 9, 32'h0,        1, 0, 9, 9, 3, 32'h0,        32'h33,       2'b01, 1, 1);
      add(0, 9, 32'h0,        1, 0, 9, 9, 3, 32'h0,        32'h33,       2'b00, 1, 1);
      add(0, 9, 32'h0,        1, 0, 9, 9, 3, 32'h0,        32'h33,       2'b00, 1, 0);
      add(0, 0, 32'h0,        0, 0, 9, 9, 3, 32'h0,        32'h33,       2'b00, 1, 0);
      // Simultaneous issue/commit
      add(0, 0, 32'h0,        0, 1, 4, 4, 2, 32'h0,        32'h0,        2'b00, 1, 0);
      add(0, 4, 32'h0,        1, 1, 4, 4, 2, 32'h0,        32'h0,        2'b00, 1, 1);
      add(0, 0, 32'h0,        0, 0, 0, 4, 2, 32'h0,        32'h0,        2'b01, 1, 1);
      add(0, 4, 32'h0,        1, 1, 2, 4, 2, 32'h0,        32'h0,        2'b00, 1, 1);
      add(0, 0, 32'h0,        0, 0, 0, 4, 2, 32'h0,        32'h0,        2'b10, 1, 1);
      add(0, 2, 32'h0,        1, 0, 0, 4, 2, 32'h0,        32'h0,        2'b00, 1, 1);
      // Issue to r0 has no effect
      add(0, 0, 32'h0,        0, 1, 0, 4, 2, 32'h0,        32'h0,        2'b00, 1, 0);
      add(0, 0, 32'h0,        0, 0, 0, 4, 2, 32'h0,        32'h0,        2'b00, 1, 0);

      // Reset with a write and bypass request present: all must be held off.
      a_idle();
      b_idle();
      a_flush = 1'b1;
      b_flush = 1'b1;
      a_we = 1'b1; a_wa = 5'd7; a_wd = 32'hFFFF_FFFF; a_ra = {5'd0, 5'd7};
      @(negedge clk);
      @(negedge clk);
      #1;
      check("reset rd", a_rd, 64'h0);
      check("reset busy", 64'(a_busy), 64'h0);
      check("reset pend", 64'(a_pend), 64'h0);
      check("reset ready", 64'(a_rdy), 64'h1);
      @(negedge clk);
      a_idle();
      a_flush = 1'b0;
      b_flush = 1'b0;

      // Table vectors on instance A
      foreach (tv[i]) begin
         @(negedge clk);
         a_we = tv[i].we; a_wa = tv[i].wa; a_wd = tv[i].wd; a_cm = tv[i].cm;
         a_iv = tv[i].iv; a_ir = tv[i].ir; a_ra = {tv[i].ra1, tv[i].ra0};
         #1;
         check($sformatf("row%0d rd0", i), 64'(a_rd[31:0]), 64'(tv[i].e_rd0));
         check($sformatf("row%0d rd1", i), 64'(a_rd[63:32]), 64'(tv[i].e_rd1));
         check($sformatf("row%0d busy", i), 64'(a_busy), 64'(tv[i].e_busy));
         check($sformatf("row%0d ready", i), 64'(a_rdy), 64'(tv[i].e_rdy));
         check($sformatf("row%0d pend", i), 64'(a_pend), 64'(tv[i].e_pend));
      end

      // Instance A: flush with live state (cnt[6]=2, r8 written)
      @(negedge clk);
      a_idle();
      a_iv = 1'b1; a_ir = 5'd6; a_we = 1'b1; a_wa = 5'd8; a_wd = 32'hAAAA5555;
      @(negedge clk);
      a_we = 1'b0;
      @(negedge clk);
      a_iv = 1'b0;
      a_we = 1'b1; a_wa = 5'd8; a_wd = 32'h5A5A; a_ra = {5'd6, 5'd8};
      #1;
      check("A preflush rd0", 64'(a_rd[31:0]), 64'h5A5A);
      check("A preflush busy", 64'(a_busy), 64'b10);
      check("A preflush pend", 64'(a_pend), 64'h1);
      a_we = 1'b0;
      #1;
      check("A preflush r8", 64'(a_rd[31:0]), 64'hAAAA5555);
      a_we = 1'b1;
      #1;
      a_flush = 1'b1;
      #1;
      check("A flush rd", a_rd, 64'h0);
      check("A flush busy", 64'(a_busy), 64'h0);
      check("A flush pend", 64'(a_pend), 64'h0);
      check("A flush ready", 64'(a_rdy), 64'h1);
      @(negedge clk);
      a_flush = 1'b0;
      a_we = 1'b0;
      a_ra = {5'd6, 5'd8};
      #1;
      check("A postflush r8", 64'(a_rd[31:0]), 64'h0);
      check("A postflush busy", 64'(a_busy), 64'h0);
      a_ra = {5'd0, 5'd5};
      #1;
      check("A postflush r5", a_rd, 64'h0);

      // Instance B: four ports with independent busy bits
      @(negedge clk);
      b_we = 1'b1; b_wa = 5'd1; b_wd = 16'h1111;
      @(negedge clk);
      b_wa = 5'd2; b_wd = 16'h2222; b_iv = 1'b1; b_ir = 5'd6;
      @(negedge clk);
      b_wa = 5'd3; b_wd = 16'h3333;
      @(negedge clk);
      b_wa = 5'd4; b_wd = 16'h4444; b_ir = 5'd2;
      @(negedge clk);
      b_idle();
      b_ra = {5'd6, 5'd3, 5'd2, 5'd1};
      #1;
      check("B rd set1", b_rd, {16'h0, 16'h3333, 16'h2222, 16'h1111});
      check("B busy set1", 64'(b_busy), 64'b1010);
      check("B pend", 64'(b_pend), 64'h1);
      b_ra = {5'd4, 5'd1, 5'd6, 5'd2};
      #1;
      check("B rd set2", b_rd, {16'h4444, 16'h1111, 16'h0, 16'h2222});
      check("B busy set2", 64'(b_busy), 64'b0011);
      b_ir = 5'd6;
      #1;
      check("B ready r6", 64'(b_rdy), 64'h1);
      b_flush = 1'b1;
      #1;
      check("B flush rd", b_rd, 64'h0);
      check("B flush busy", 64'(b_busy), 64'h0);
      check("B flush pend", 64'(b_pend), 64'h0);
      @(negedge clk);
      b_flush = 1'b0;
      #1;
      check("B postflush rd", b_rd, 64'h0);
      check("B postflush busy", 64'(b_busy), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
